// File: rtl/branch_predict_unit_pkg.sv
// Shared types and helpers for the branch prediction unit: 2-bit saturating
// counter type, its reset value and update/predict functions.
package branch_predict_unit_pkg;

    typedef logic [1:0] bpu_ctr_t;

    localparam bpu_ctr_t BPU_CTR_RESET = 2'b01;

    function automatic bpu_ctr_t bpu_ctr_update(input bpu_ctr_t ctr, input logic taken);
        bpu_ctr_t res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    function automatic logic bpu_predict_taken(input bpu_ctr_t ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/branch_spec_queue.sv
// In-order FIFO of unresolved conditional branches. Pop is applied before push
// so a full queue can accept while it drains; clear overrides both.
module branch_spec_queue
    import branch_predict_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty     = (count_r == CNT_W'(0));
    assign full      = (count_r == CNT_W'(DEPTH));
    assign do_pop_s  = pop && !empty && !clear;
    assign do_push_s = push && (!full || do_pop_s) && !clear;
    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer, occupancy and storage update
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with an in-order queue of unresolved branches and
// one-cycle flush on mispredict. Define BRANCH_PREDICT_GSHARE_EN for gshare indexing.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int SPEC_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic                  branch_conditional,
    input  logic [0:ADDR_WIDTH-1] branch_target,
    input  logic [0:ADDR_WIDTH-1] current_instruction_address,
    output logic                  next_valid,
    output logic [0:ADDR_WIDTH-1] next_instruction_address,
    output logic                  speculative,
    input  logic                  resolve_valid,
    input  logic                  resolve_taken,
    output logic                  flush,
    output logic [0:ADDR_WIDTH-1] flush_address
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int CNT_W = $clog2(SPEC_DEPTH) + 1;

    typedef struct packed {
        logic [IDX_W-1:0]      index;
        logic                  predicted;
        logic [ADDR_WIDTH-1:0] alternate;
    } bpu_entry_t;

    bpu_ctr_t              bht_r [BHT_ENTRIES];
    logic                  next_valid_r;
    logic [ADDR_WIDTH-1:0] next_addr_r;
    logic                  speculative_r;
    logic                  flush_r;
    logic [ADDR_WIDTH-1:0] flush_addr_r;

    logic [IDX_W-1:0]      pc_idx_s;
    logic [IDX_W-1:0]      rd_idx_s;
    logic                  pred_taken_s;
    logic [ADDR_WIDTH-1:0] fall_through_s;
    logic [ADDR_WIDTH-1:0] next_addr_s;
    logic                  resolve_fire_s;
    logic                  mispredict_s;
    logic                  input_ready_s;
    logic                  issue_s;
    logic                  push_s;
    bpu_entry_t            push_entry_s;
    bpu_entry_t            head_s;
    logic [CNT_W-1:0]      q_count_s;
    logic [CNT_W-1:0]      count_next_s;
    logic                  q_full_s;
    logic                  q_empty_s;

    // Word-address bits just above the byte offset select the counter
    assign pc_idx_s = current_instruction_address[ADDR_WIDTH-2-IDX_W : ADDR_WIDTH-3];

`ifdef BRANCH_PREDICT_GSHARE_EN
    logic [IDX_W-1:0] hist_r;

    assign rd_idx_s = pc_idx_s ^ hist_r;

    // Committed-outcome history, advanced only on real resolutions
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_r <= IDX_W'(0);
        end else if (resolve_fire_s) begin
            hist_r <= {hist_r[IDX_W-2:0], resolve_taken};
        end
    end
`else
    assign rd_idx_s = pc_idx_s;
`endif

    assign pred_taken_s   = bpu_predict_taken(bht_r[rd_idx_s]);
    assign fall_through_s = current_instruction_address + ADDR_WIDTH'(4);
    assign next_addr_s    = (!branch_conditional || pred_taken_s) ? branch_target : fall_through_s;

    assign resolve_fire_s = resolve_valid && !q_empty_s;
    assign mispredict_s   = resolve_fire_s && (resolve_taken != head_s.predicted);
    // A full queue still accepts when the oldest entry pops this cycle
    assign input_ready_s  = !rst && !flush_r && (!q_full_s || resolve_fire_s);
    assign issue_s        = input_valid && input_ready_s && !mispredict_s;
    assign push_s         = issue_s && branch_conditional;
    assign count_next_s   = mispredict_s ? CNT_W'(0)
                          : q_count_s + CNT_W'(push_s) - CNT_W'(resolve_fire_s);

    // Queue entry for the branch being accepted
    always_comb begin
        push_entry_s           = '0;
        push_entry_s.index     = rd_idx_s;
        push_entry_s.predicted = pred_taken_s;
        push_entry_s.alternate = pred_taken_s ? fall_through_s : branch_target;
    end

    branch_spec_queue #(
        .WIDTH ($bits(bpu_entry_t)),
        .DEPTH (SPEC_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (resolve_fire_s),
        .clear     (mispredict_s),
        .push_data (push_entry_s),
        .head_data (head_s),
        .count     (q_count_s),
        .full      (q_full_s),
        .empty     (q_empty_s)
    );

    // Counter training from the resolving entry's stored index
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= BPU_CTR_RESET;
            end
        end else if (resolve_fire_s) begin
            bht_r[head_s.index] <= bpu_ctr_update(bht_r[head_s.index], resolve_taken);
        end
    end

    // Registered fetch-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            next_valid_r  <= 1'b0;
            next_addr_r   <= ADDR_WIDTH'(0);
            speculative_r <= 1'b0;
            flush_r       <= 1'b0;
            flush_addr_r  <= ADDR_WIDTH'(0);
        end else begin
            next_valid_r  <= issue_s;
            speculative_r <= (count_next_s != CNT_W'(0));
            flush_r       <= mispredict_s;
            if (issue_s) begin
                next_addr_r <= next_addr_s;
            end
            if (mispredict_s) begin
                flush_addr_r <= head_s.alternate;
            end
        end
    end

    assign input_ready              = input_ready_s;
    assign next_valid               = next_valid_r;
    assign next_instruction_address = next_addr_r;
    assign speculative              = speculative_r;
    assign flush                    = flush_r;
    assign flush_address            = flush_addr_r;

endmodule
